// File: rtl/mem_port_arbiter.sv
// Shares one single-port backing memory between the fetch and load/store paths.
// Data accesses win arbitration; a saturating starvation counter forces a fetch grant.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iReqValid,
    input  logic [ADDR_W-1:0] iReqAddr,
    output logic              iRespValid,
    output logic [DATA_W-1:0] iRespData,
    input  logic              dReqValid,
    input  logic              dReqWrite,
    input  logic [ADDR_W-1:0] dReqAddr,
    input  logic [DATA_W-1:0] dReqWData,
    output logic              dRespValid,
    output logic [DATA_W-1:0] dRespData,
    output logic              memReqValid,
    output logic              memReqWrite,
    output logic [ADDR_W-1:0] memReqAddr,
    output logic [DATA_W-1:0] memReqWData,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memRData,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEM_I = 2'd1,
        MEM_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            state;
    logic [3:0]        starveCnt;
    logic [ADDR_W-1:0] latAddr;
    logic              latWrite;
    logic [DATA_W-1:0] latWData;
    logic [DATA_W-1:0] capData;
    logic              ownerD;
    logic              grantD;

    // A waiting fetch overrides data priority only once the counter has saturated.
    assign grantD = dReqValid && !(iReqValid && (starveCnt == LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            starveCnt <= '0;
            latAddr   <= '0;
            latWrite  <= 1'b0;
            latWData  <= '0;
            capData   <= '0;
            ownerD    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantD) begin
                        latAddr  <= dReqAddr;
                        latWrite <= dReqWrite;
                        latWData <= dReqWData;
                        if (iReqValid && (starveCnt < LIMIT))
                            starveCnt <= starveCnt + 4'd1;
                        state <= MEM_D;
                    end else if (iReqValid) begin
                        latAddr   <= iReqAddr;
                        latWrite  <= 1'b0;
                        latWData  <= '0;
                        starveCnt <= '0;
                        state     <= MEM_I;
                    end
                end
                MEM_I, MEM_D: begin
                    if (memAck) begin
                        capData <= latWrite ? '0 : memRData;
                        ownerD  <= (state == MEM_D);
                        state   <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode only state and latched registers; no input reaches an output.
    assign busy        = (state != IDLE);
    assign memReqValid = (state == MEM_I) || (state == MEM_D);
    assign memReqWrite = (state == MEM_D) && latWrite;
    assign memReqAddr  = latAddr;
    assign memReqWData = latWData;
    assign iRespValid  = (state == RESP) && !ownerD;
    assign dRespValid  = (state == RESP) && ownerD;
    assign iRespData   = iRespValid ? capData : '0;
    assign dRespData   = dRespValid ? capData : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter: a memory responder with variable latency
// plus a transaction-level model of arbitration, starvation and data flow.
module tb_mem_port_arbiter;

    localparam int unsigned LIMIT = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          iReqValid;
    logic [AW-1:0] iReqAddr;
    logic          iRespValid;
    logic [DW-1:0] iRespData;
    logic          dReqValid;
    logic          dReqWrite;
    logic [AW-1:0] dReqAddr;
    logic [DW-1:0] dReqWData;
    logic          dRespValid;
    logic [DW-1:0] dRespData;
    logic          memReqValid;
    logic          memReqWrite;
    logic [AW-1:0] memReqAddr;
    logic [DW-1:0] memReqWData;
    logic          memAck;
    logic [DW-1:0] memRData;
    logic          busy;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .iReqValid(iReqValid), .iReqAddr(iReqAddr),
        .iRespValid(iRespValid), .iRespData(iRespData),
        .dReqValid(dReqValid), .dReqWrite(dReqWrite), .dReqAddr(dReqAddr),
        .dReqWData(dReqWData), .dRespValid(dRespValid), .dRespData(dRespData),
        .memReqValid(memReqValid), .memReqWrite(memReqWrite),
        .memReqAddr(memReqAddr), .memReqWData(memReqWData),
        .memAck(memAck), .memRData(memRData), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] memArr [0:15];
    logic [DW-1:0] shadow [0:15];
    bit memAuto   = 1'b1;
    bit manualAck = 1'b0;
    int memWaitMin = 0;
    int memWaitMax = 0;

    // Memory responder: drives at posedge+1, the main thread acts at posedge+2.
    initial begin : responder
        int  waitLeft;
        bit  armed;
        armed    = 1'b0;
        waitLeft = 0;
        memAck   = 1'b0;
        memRData = '0;
        forever begin
            @(posedge clk);
            #1;
            memAck   = 1'b0;
            memRData = $urandom;
            if (!memAuto) begin
                memAck = manualAck;
                armed  = 1'b0;
            end else if (memReqValid) begin
                if (!armed) begin
                    waitLeft = $urandom_range(memWaitMax, memWaitMin);
                    armed    = 1'b1;
                end
                if (waitLeft == 0) begin
                    memAck = 1'b1;
                    armed  = 1'b0;
                    if (memReqWrite) memArr[memReqAddr[5:2]] = memReqWData;
                    else             memRData = memArr[memReqAddr[5:2]];
                end else begin
                    waitLeft--;
                end
            end else begin
                armed = 1'b0;
            end
        end
    end

    // Transaction-level model state
    int            cnt = 0;
    int            phase;
    bit            gD;
    bit            gWrite;
    logic [AW-1:0] gAddr;
    logic [DW-1:0] gWData;
    logic [DW-1:0] expData;
    bit            grantLog [$];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [AW-1:0] randAddr();
        logic [AW-1:0] a;
        a = AW'($urandom_range(15, 0)) << 2;
        return a;
    endfunction

    task automatic runTraffic(input int cycles, input int pI, input int pD, input bit scramble);
        bit            cI, cD, cW, cAck;
        logic [AW-1:0] cIA, cDA;
        logic [DW-1:0] cDD;
        logic [3:0]    idx;
        cI = iReqValid; cD = dReqValid; cW = dReqWrite;
        cIA = iReqAddr; cDA = dReqAddr; cDD = dReqWData; cAck = 1'b0;
        phase = 0;
        for (int c = 0; c < cycles + 30; c++) begin
            tick();
            case (phase)
                0: if (cI || cD) begin
                    gD     = cD && !(cI && (cnt == LIMIT));
                    gWrite = gD && cW;
                    gAddr  = gD ? cDA : cIA;
                    gWData = gWrite ? cDD : '0;
                    idx    = gAddr[5:2];
                    if (gWrite) begin
                        shadow[idx] = cDD;
                        expData     = '0;
                    end else begin
                        expData = shadow[idx];
                    end
                    if (gD) begin
                        if (cI && cnt < LIMIT) cnt++;
                    end else begin
                        cnt = 0;
                    end
                    grantLog.push_back(gD);
                    phase = 1;
                end
                1: if (cAck) phase = 2;
                default: phase = 0;
            endcase
            tests++;
            if (busy !== (phase != 0)) begin
                fails++; $display("FAIL busy: got %b expected %b (cycle %0d)", busy, phase != 0, c);
            end
            tests++;
            if (memReqValid !== (phase == 1)) begin
                fails++; $display("FAIL memReqValid: got %b expected %b (cycle %0d)", memReqValid, phase == 1, c);
            end
            if (phase == 1) begin
                tests++;
                if (memReqAddr !== gAddr || memReqWrite !== gWrite) begin
                    fails++;
                    $display("FAIL memReq: got addr %h wr %b expected addr %h wr %b", memReqAddr, memReqWrite, gAddr, gWrite);
                end
                if (gWrite) begin
                    tests++;
                    if (memReqWData !== gWData) begin
                        fails++; $display("FAIL memReqWData: got %h expected %h", memReqWData, gWData);
                    end
                end
            end
            tests++;
            if (iRespValid !== (phase == 2 && !gD) || dRespValid !== (phase == 2 && gD)) begin
                fails++;
                $display("FAIL respValid: got i%b d%b expected i%b d%b", iRespValid, dRespValid, phase == 2 && !gD, phase == 2 && gD);
            end
            if (phase == 2) begin
                tests++;
                if ((gD ? dRespData : iRespData) !== expData) begin
                    fails++; $display("FAIL respData: got %h expected %h", gD ? dRespData : iRespData, expData);
                end
                if (gD) dReqValid = 1'b0;
                else    iReqValid = 1'b0;
            end
            if (scramble && phase == 1) begin
                if (gD) begin
                    dReqAddr  = randAddr();
                    dReqWData = $urandom;
                end else begin
                    iReqAddr = randAddr();
                end
            end
            if (c < cycles) begin
                if (!iReqValid && $urandom_range(99, 0) < pI) begin
                    iReqValid = 1'b1;
                    iReqAddr  = randAddr();
                end
                if (!dReqValid && $urandom_range(99, 0) < pD) begin
                    dReqValid = 1'b1;
                    dReqWrite = $urandom_range(1, 0) == 1;
                    dReqAddr  = randAddr();
                    dReqWData = $urandom;
                end
            end
            cI = iReqValid; cD = dReqValid; cW = dReqWrite;
            cIA = iReqAddr; cDA = dReqAddr; cDD = dReqWData; cAck = memAck;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        tests++;
        if ({iRespValid, dRespValid, memReqValid, memReqWrite, busy} !== 5'b0) begin
            fails++; $display("FAIL reset_flags: got %b expected 00000", {iRespValid, dRespValid, memReqValid, memReqWrite, busy});
        end
        tests++;
        if ({iRespData, dRespData, memReqAddr, memReqWData} !== '0) begin
            fails++; $display("FAIL reset_data: got %h expected 0", {iRespData, dRespData, memReqAddr, memReqWData});
        end
        rst = 1'b0;
        cnt = 0;
    endtask

    task automatic test_single_fetch();
        memWaitMin = 0; memWaitMax = 0;
        memArr[0] = 32'h2001_0002; shadow[0] = 32'h2001_0002;
        iReqValid = 1'b1; iReqAddr = 32'h40;
        tick();
        tests++;
        if (memReqValid !== 1'b1 || memReqAddr !== 32'h40 || memReqWrite !== 1'b0) begin
            fails++; $display("FAIL fetch_req: got v%b addr %h wr %b expected v1 addr 00000040 wr 0", memReqValid, memReqAddr, memReqWrite);
        end
        tick();
        tests++;
        if (iRespValid !== 1'b1 || iRespData !== 32'h2001_0002) begin
            fails++; $display("FAIL fetch_resp: got v%b data %h expected v1 data 20010002", iRespValid, iRespData);
        end
        iReqValid = 1'b0;
        tick();
        tests++;
        if (busy !== 1'b0 || iRespValid !== 1'b0) begin
            fails++; $display("FAIL fetch_done: got busy %b resp %b expected 0 0", busy, iRespValid);
        end
        cnt = 0;
    endtask

    task automatic dAccess(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [DW-1:0] exp);
        bit got = 1'b0;
        bit sawReq = 1'b0;
        dReqValid = 1'b1; dReqWrite = wr; dReqAddr = a; dReqWData = wd;
        for (int c = 1; c <= 20 && !got; c++) begin
            tick();
            if (memReqValid && !sawReq) begin
                sawReq = 1'b1;
                tests++;
                if (memReqWrite !== wr) begin
                    fails++; $display("FAIL d_write_strobe: got %b expected %b", memReqWrite, wr);
                end
            end
            if (dRespValid) begin
                got = 1'b1;
                tests++;
                if (dRespData !== exp || c != 4) begin
                    fails++; $display("FAIL d_resp: got data %h at cycle %0d expected %h at cycle 4", dRespData, c, exp);
                end
                dReqValid = 1'b0;
            end
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL d_resp_timeout: got no response expected one within 20 cycles");
        end
        tick();
    endtask

    task automatic test_store_load();
        memWaitMin = 2; memWaitMax = 2;
        dAccess(1'b1, 32'h8, 32'h14, 32'h0);
        shadow[2] = 32'h14;
        dAccess(1'b0, 32'h8, 32'h0, 32'h14);
    endtask

    task automatic test_simultaneous();
        int iCount = 0, dCount = 0, iCycle = -1;
        memWaitMin = 0; memWaitMax = 0;
        iReqValid = 1'b1; iReqAddr = 32'h10;
        dReqValid = 1'b1; dReqWrite = 1'b0; dReqAddr = 32'h20;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1 || c == 4) begin
                tests++;
                if (memReqValid !== 1'b1 || memReqAddr !== (c == 1 ? 32'h20 : 32'h10)) begin
                    fails++; $display("FAIL simul_grant: got v%b addr %h at cycle %0d expected v1 addr %h", memReqValid, memReqAddr, c, c == 1 ? 32'h20 : 32'h10);
                end
            end
            if (dRespValid) begin
                dCount++; dReqValid = 1'b0;
                tests++;
                if (dRespData !== shadow[8]) begin
                    fails++; $display("FAIL simul_ddata: got %h expected %h", dRespData, shadow[8]);
                end
            end
            if (iRespValid) begin
                iCount++; iReqValid = 1'b0; iCycle = c;
                tests++;
                if (iRespData !== shadow[4]) begin
                    fails++; $display("FAIL simul_idata: got %h expected %h", iRespData, shadow[4]);
                end
            end
        end
        tests++;
        if (iCount != 1 || dCount != 1 || iCycle != 5) begin
            fails++; $display("FAIL simul_pulses: got i%0d d%0d icycle %0d expected i1 d1 icycle 5", iCount, dCount, iCycle);
        end
        cnt = 0;
    endtask

    task automatic test_starvation();
        test_reset();
        memWaitMin = 0; memWaitMax = 0;
        grantLog.delete();
        runTraffic(60, 100, 100, 1'b0);
        tests++;
        if (grantLog.size() < 15) begin
            fails++; $display("FAIL starve_count: got %0d grants expected at least 15", grantLog.size());
        end else begin
            for (int k = 0; k < 15; k++) begin
                tests++;
                if (grantLog[k] !== (k % 5 != 4)) begin
                    fails++; $display("FAIL starve_order: got grantD %b at grant %0d expected %b", grantLog[k], k, k % 5 != 4);
                end
            end
        end
    endtask

    task automatic test_random();
        memWaitMin = 0; memWaitMax = 3;
        runTraffic(400, 30, 50, 1'b0);
        memWaitMin = 0; memWaitMax = 0;
        runTraffic(200, 60, 70, 1'b0);
    endtask

    task automatic test_input_change();
        memWaitMin = 1; memWaitMax = 3;
        runTraffic(300, 40, 60, 1'b1);
    endtask

    task automatic test_mid_access_reset();
        bit okAck = 1'b0;
        memAuto = 1'b0;
        manualAck = 1'b0;
        dReqValid = 1'b1; dReqWrite = 1'b0; dReqAddr = 32'h30;
        tick();
        tick();
        tests++;
        if (memReqValid !== 1'b1) begin
            fails++; $display("FAIL midrst_inflight: got memReqValid %b expected 1", memReqValid);
        end
        rst = 1'b1; dReqValid = 1'b0;
        tick();
        rst = 1'b0;
        tests++;
        if ({iRespValid, dRespValid, memReqValid, memReqWrite, busy, iRespData, dRespData, memReqAddr, memReqWData} !== '0) begin
            fails++; $display("FAIL midrst_outputs: got busy %b memReqValid %b addr %h expected all 0", busy, memReqValid, memReqAddr);
        end
        manualAck = 1'b1;
        tick();
        okAck = memAck;
        manualAck = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            tests++;
            if ({iRespValid, dRespValid, memReqValid, busy} !== 4'b0) begin
                fails++; $display("FAIL midrst_idle: got %b expected 0000 (cycle %0d, late ack %b)", {iRespValid, dRespValid, memReqValid, busy}, c, okAck);
            end
        end
        memAuto = 1'b1;
        cnt = 0;
        memWaitMin = 0; memWaitMax = 2;
        runTraffic(100, 40, 50, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        iReqValid = 1'b0; iReqAddr = '0;
        dReqValid = 1'b0; dReqWrite = 1'b0; dReqAddr = '0; dReqWData = '0;
        for (int i = 0; i < 16; i++) begin
            memArr[i] = $urandom;
            shadow[i] = memArr[i];
        end
        test_reset();
        test_single_fetch();
        test_store_load();
        test_simultaneous();
        test_starvation();
        test_random();
        test_input_change();
        test_mid_access_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
